// File: rtl/ram_loader.sv
// Byte-stream loader for the data RAM: packs bytes little-endian into words and
// writes them to consecutive addresses, tracking progress, completion and checksum.
module ram_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int LOAD_WORDS = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   words_loaded,
    output logic [DATA_WIDTH-1:0] checksum
);

    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int CNT_WIDTH      = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [CNT_WIDTH-1:0]  LAST_IDX   = CNT_WIDTH'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_WIDTH:0]   LOAD_COUNT = (ADDR_WIDTH + 1)'(LOAD_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CNT_WIDTH-1:0]  byte_cnt;
    logic [DATA_WIDTH-1:0] asm_word;
    logic [DATA_WIDTH-1:0] word_next;
    logic [ADDR_WIDTH:0]   words_inc;
    logic                  accept;
    logic                  last_byte;

    assign byte_ready = (state == COLLECT);
    assign busy       = (state != IDLE);
    assign accept     = byte_ready && byte_valid;
    assign last_byte  = (byte_cnt == LAST_IDX);
    assign words_inc  = words_loaded + 1'b1;

    // Assembly register with the incoming byte merged into its lane.
    always_comb begin
        word_next                   = asm_word;
        word_next[8*byte_cnt +: 8]  = byte_in;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = COLLECT;
            COLLECT: begin
                if (abort)                      state_next = IDLE;
                else if (accept && last_byte)   state_next = WRITE;
            end
            WRITE: begin
                if (abort || words_inc == LOAD_COUNT) state_next = IDLE;
                else                                  state_next = COLLECT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values of the others.
            state <= state_next;
        end
    end

    // ram_we is raised on entry to WRITE so it is high exactly for the WRITE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt     <= '0;
            asm_word     <= '0;
            ram_addr     <= '0;
            ram_data     <= '0;
            ram_we       <= 1'b0;
            done         <= 1'b0;
            words_loaded <= '0;
            checksum     <= '0;
        end else begin
            ram_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        byte_cnt     <= '0;
                        asm_word     <= '0;
                        done         <= 1'b0;
                        words_loaded <= '0;
                        checksum     <= '0;
                    end
                end
                COLLECT: begin
                    if (!abort && accept) begin
                        if (last_byte) begin
                            ram_we   <= 1'b1;
                            ram_addr <= words_loaded[ADDR_WIDTH-1:0];
                            ram_data <= word_next;
                            byte_cnt <= '0;
                            asm_word <= '0;
                        end else begin
                            asm_word <= word_next;
                            byte_cnt <= byte_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                WRITE: begin
                    checksum     <= checksum + ram_data;
                    words_loaded <= words_inc;
                    byte_cnt     <= '0;
                    if (!abort && words_inc == LOAD_COUNT) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: a 4-word and a default 64-word instance,
// randomized byte streams checked against a word-level model of the expected writes.
module tb_ram_loader;

    localparam int BPW = 2;
    localparam int LOG = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic [1:0]  start = 2'b00;
    logic [1:0]  abort = 2'b00;
    logic [1:0]  byte_ready, ram_we, busy, done;
    logic [5:0]  ram_addr [2];
    logic [15:0] ram_data [2];
    logic [15:0] checksum [2];
    logic [6:0]  words_loaded [2];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0]  tx [LOG];
    logic [7:0]  acc_byte [2][LOG];
    int          acc_cyc  [2][LOG];
    int          n_acc    [2] = '{0, 0};
    logic [5:0]  wr_addr  [2][LOG];
    logic [15:0] wr_data  [2][LOG];
    int          wr_cyc   [2][LOG];
    int          n_wr     [2] = '{0, 0};

    ram_loader #(.LOAD_WORDS(4)) u_small (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready[0]),
        .ram_addr(ram_addr[0]), .ram_data(ram_data[0]), .ram_we(ram_we[0]),
        .busy(busy[0]), .done(done[0]), .words_loaded(words_loaded[0]),
        .checksum(checksum[0])
    );

    ram_loader u_full (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready[1]),
        .ram_addr(ram_addr[1]), .ram_data(ram_data[1]), .ram_we(ram_we[1]),
        .busy(busy[1]), .done(done[1]), .words_loaded(words_loaded[1]),
        .checksum(checksum[1])
    );

    always #5 clk = ~clk;

    // Log every handshake and every RAM write as the RAM itself would see them.
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (byte_valid && byte_ready[d]) begin
                if (n_acc[d] < LOG) begin
                    acc_byte[d][n_acc[d]] = byte_in;
                    acc_cyc[d][n_acc[d]]  = cyc;
                end
                n_acc[d] = n_acc[d] + 1;
            end
            if (ram_we[d]) begin
                if (n_wr[d] < LOG) begin
                    wr_addr[d][n_wr[d]] = ram_addr[d];
                    wr_data[d][n_wr[d]] = ram_data[d];
                    wr_cyc[d][n_wr[d]]  = cyc;
                end
                n_wr[d] = n_wr[d] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_zero(input int d);
        check("rst_byte_ready", {31'b0, byte_ready[d]}, 0);
        check("rst_ram_addr", {26'b0, ram_addr[d]}, 0);
        check("rst_ram_data", {16'b0, ram_data[d]}, 0);
        check("rst_ram_we", {31'b0, ram_we[d]}, 0);
        check("rst_busy", {31'b0, busy[d]}, 0);
        check("rst_done", {31'b0, done[d]}, 0);
        check("rst_words_loaded", {25'b0, words_loaded[d]}, 0);
        check("rst_checksum", {16'b0, checksum[d]}, 0);
    endtask

    task automatic pulse_start(input int d);
        start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
        check("start_busy", {31'b0, busy[d]}, 1);
        check("start_done_clr", {31'b0, done[d]}, 0);
        check("start_wl_clr", {25'b0, words_loaded[d]}, 0);
        check("start_cks_clr", {16'b0, checksum[d]}, 0);
    endtask

    task automatic pulse_abort(input int d);
        abort[d] = 1'b1;
        @(posedge clk); #1;
        abort[d] = 1'b0;
    endtask

    // Present tx[0..n-1] in order, holding each byte until it is taken.
    task automatic drive(input int d, input int n, input int min_gap, input int max_gap);
        logic got;
        int   k;
        int   gap;
        for (int i = 0; i < n; i++) begin
            byte_in    = tx[i];
            byte_valid = 1'b1;
            got        = 1'b0;
            k          = 0;
            while (!got && k < 50) begin
                @(negedge clk);
                got = byte_ready[d];
                @(posedge clk); #1;
                k++;
            end
            if (!got) check("accept_timeout", {31'b0, got}, 1);
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, min_gap)) : 0;
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int k = 0;
        while (!done[d] && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        check("done", {31'b0, done[d]}, 1);
        check("idle_after_done", {31'b0, busy[d]}, 0);
    endtask

    // Word-level model: word j is tx[2j] | tx[2j+1]<<8, written to address j
    // one cycle after its last byte is taken; checksum is their 16-bit sum.
    task automatic check_load(input int d, input int a0, input int w0, input int nwords);
        logic [15:0] exp_word;
        logic [15:0] sum = 16'h0;
        check("n_accepted", n_acc[d] - a0, BPW * nwords);
        check("n_writes", n_wr[d] - w0, nwords);
        for (int j = 0; j < nwords; j++) begin
            exp_word = {tx[2*j+1], tx[2*j]};
            sum      = sum + exp_word;
            check("acc_bytes", {16'b0, acc_byte[d][a0+2*j+1], acc_byte[d][a0+2*j]}, {16'b0, exp_word});
            check("wr_addr", {26'b0, wr_addr[d][w0+j]}, j);
            check("wr_data", {16'b0, wr_data[d][w0+j]}, {16'b0, exp_word});
            check("wr_latency", wr_cyc[d][w0+j] - acc_cyc[d][a0+2*j+1], 1);
        end
        check("checksum", {16'b0, checksum[d]}, {16'b0, sum});
        check("words_loaded", {25'b0, words_loaded[d]}, nwords);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) tx[i] = 8'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, w0, done_cyc;

        // Asynchronous reset between edges, then no activity without start.
        #3 rst = 1'b1;
        #1;
        check_zero(0);
        check_zero(1);
        byte_valid = 1'b1;
        byte_in    = 8'hAA;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        a0 = n_acc[0];
        repeat (3) begin
            @(negedge clk);
            check("ready_without_start", {31'b0, byte_ready[0] | byte_ready[1]}, 0);
        end
        check("no_accept_idle", n_acc[0] - a0, 0);
        byte_valid = 1'b0;
        @(posedge clk); #1;

        // Four-word load of 01..08 with a continuous stream.
        for (int i = 0; i < 8; i++) tx[i] = 8'(i + 1);
        a0 = n_acc[0];
        w0 = n_wr[0];
        pulse_start(0);
        drive(0, 8, 0, 0);
        wait_done(0);
        done_cyc = cyc;
        check_load(0, a0, w0, 4);
        check("load_cycles", done_cyc - acc_cyc[0][a0] + 1, 4 * (BPW + 1));
        repeat (6) @(posedge clk);
        #1;
        check("no_extra_write_4", n_wr[0] - w0, 4);

        // Full 64-word load, word i = i, source idles one cycle after every byte.
        for (int i = 0; i < 64; i++) begin
            tx[2*i]   = 8'(i);
            tx[2*i+1] = 8'h00;
        end
        a0 = n_acc[1];
        w0 = n_wr[1];
        pulse_start(1);
        drive(1, 128, 1, 1);
        wait_done(1);
        check_load(1, a0, w0, 64);
        check("checksum_64", {16'b0, checksum[1]}, 32'h07E0);
        repeat (6) @(posedge clk);
        #1;
        check("no_extra_write_64", n_wr[1] - w0, 64);

        // Abort with a partial word pending; done from the previous load must clear.
        fill_random(3);
        a0 = n_acc[0];
        w0 = n_wr[0];
        pulse_start(0);
        drive(0, 3, 0, 2);
        pulse_abort(0);
        check("abort_busy", {31'b0, busy[0]}, 0);
        check("abort_done", {31'b0, done[0]}, 0);
        check("abort_writes", n_wr[0] - w0, 1);
        check("abort_addr", {26'b0, wr_addr[0][w0]}, 0);
        check("abort_data", {16'b0, wr_data[0][w0]}, {16'b0, tx[1], tx[0]});
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_late_write", n_wr[0] - w0, 1);

        // Reload after abort: fresh words from address 0, nothing left over.
        fill_random(8);
        a0 = n_acc[0];
        w0 = n_wr[0];
        pulse_start(0);
        drive(0, 8, 0, 2);
        wait_done(0);
        check_load(0, a0, w0, 4);

        // Abort during the WRITE cycle: that write still lands, done stays 0.
        fill_random(2);
        w0 = n_wr[0];
        pulse_start(0);
        drive(0, 2, 0, 0);
        check("in_write_we", {31'b0, ram_we[0]}, 1);
        pulse_abort(0);
        check("wabort_writes", n_wr[0] - w0, 1);
        check("wabort_busy", {31'b0, busy[0]}, 0);
        check("wabort_done", {31'b0, done[0]}, 0);

        // start pulsed mid-load is ignored.
        fill_random(8);
        a0 = n_acc[0];
        w0 = n_wr[0];
        pulse_start(0);
        fork
            drive(0, 8, 0, 1);
            begin
                repeat (4) @(posedge clk);
                #1 start[0] = 1'b1;
                @(posedge clk);
                #1 start[0] = 1'b0;
            end
        join
        wait_done(0);
        check_load(0, a0, w0, 4);

        // start with done=1 clears done on the starting edge; then abort back to idle.
        pulse_start(0);
        pulse_abort(0);
        check("abort_to_idle", {31'b0, busy[0]}, 0);

        // start and abort together in IDLE: start wins.
        start[0] = 1'b1;
        abort[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        abort[0] = 1'b0;
        check("start_beats_abort", {31'b0, busy[0]}, 1);
        pulse_abort(0);

        // Randomized full load with random gaps on the default instance.
        fill_random(128);
        a0 = n_acc[1];
        w0 = n_wr[1];
        pulse_start(1);
        drive(1, 128, 0, 2);
        wait_done(1);
        check_load(1, a0, w0, 64);

        // Asynchronous reset in the middle of a WRITE cycle.
        fill_random(2);
        pulse_start(0);
        drive(0, 2, 0, 0);
        check("pre_rst_we", {31'b0, ram_we[0]}, 1);
        w0 = n_wr[0];
        #2 rst = 1'b1;
        #1;
        check_zero(0);
        @(posedge clk); #1;
        check("rst_blocks_write", n_wr[0] - w0, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_zero(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
